// File: rtl/param_shift_reg.sv
// ============================================================================
// Module      : param_shift_reg
// Description : Multi-word shift register (hold / right / left / parallel load)
//               with clock enable, synchronous clear and saturating fill count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module param_shift_reg #(
    parameter int               WIDTH   = 8,
    parameter int               DEPTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic                         clr,
    input  logic [1:0]                   mode,
    input  logic [WIDTH-1:0]             sin,
    input  logic [WIDTH*DEPTH-1:0]       pin,
    output logic [WIDTH*DEPTH-1:0]       q,
    output logic [WIDTH-1:0]             sout_r,
    output logic [WIDTH-1:0]             sout_l,
    output logic [$clog2(DEPTH+1)-1:0]   fill,
    output logic                         full
);

    localparam int                     FW         = $clog2(DEPTH + 1);
    localparam logic [FW-1:0]          c_FILL_MAX = FW'(DEPTH);
    localparam logic [WIDTH*DEPTH-1:0] c_Q_RST    = {DEPTH{RST_VAL}};

    localparam logic [1:0] c_MODE_HOLD  = 2'b00;
    localparam logic [1:0] c_MODE_RIGHT = 2'b01;
    localparam logic [1:0] c_MODE_LEFT  = 2'b10;
    localparam logic [1:0] c_MODE_LOAD  = 2'b11;

    logic [WIDTH*DEPTH-1:0] r_q;
    logic [WIDTH*DEPTH-1:0] w_shr;
    logic [WIDTH*DEPTH-1:0] w_shl;
    logic [FW-1:0]          r_fill;
    logic [FW-1:0]          w_fill_inc;

    // A single stage has no neighbours: both directions just capture sin.
    generate
        if (DEPTH == 1) begin : g_single
            assign w_shr = sin;
            assign w_shl = sin;
        end else begin : g_multi
            assign w_shr = {r_q[WIDTH*(DEPTH-1)-1:0], sin};
            assign w_shl = {sin, r_q[WIDTH*DEPTH-1:WIDTH]};
        end
    endgenerate

    assign w_fill_inc = (r_fill == c_FILL_MAX) ? r_fill : r_fill + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q    <= c_Q_RST;
            r_fill <= '0;
        end else if (clr) begin
            r_q    <= c_Q_RST;
            r_fill <= '0;
        end else if (en) begin
            case (mode)
                c_MODE_RIGHT: begin
                    r_q    <= w_shr;
                    r_fill <= w_fill_inc;
                end
                c_MODE_LEFT: begin
                    r_q    <= w_shl;
                    r_fill <= w_fill_inc;
                end
                c_MODE_LOAD: begin
                    r_q    <= pin;
                    r_fill <= c_FILL_MAX;
                end
                c_MODE_HOLD: begin
                    r_q    <= r_q;
                    r_fill <= r_fill;
                end
                default: begin
                    r_q    <= r_q;
                    r_fill <= r_fill;
                end
            endcase
        end
    end

    assign q      = r_q;
    assign sout_r = r_q[WIDTH*DEPTH-1 -: WIDTH];
    assign sout_l = r_q[WIDTH-1:0];
    assign fill   = r_fill;
    assign full   = (r_fill == c_FILL_MAX);

endmodule

`default_nettype wire

// File: tb/tb_param_shift_reg.sv
// ============================================================================
// Module      : tb_param_shift_reg
// Description : Self-checking bench for param_shift_reg (three configurations).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_param_shift_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        clr;
    logic [1:0]  mode;
    logic [7:0]  sin;
    logic [31:0] pin;

    logic [31:0] q_a, q_b;
    logic [7:0]  q_c;
    logic [7:0]  sr_a, sl_a, sr_b, sl_b, sr_c, sl_c;
    logic [2:0]  fill_a, fill_b;
    logic [0:0]  fill_c;
    logic        full_a, full_b, full_c;

    int n_pass  = 0;
    int n_total = 0;
    bit cmp_on  = 1'b0;

    always #5 clk = ~clk;

    param_shift_reg #(.WIDTH(8), .DEPTH(4), .RST_VAL(8'h00)) u_dut_a (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .mode(mode), .sin(sin), .pin(pin),
        .q(q_a), .sout_r(sr_a), .sout_l(sl_a), .fill(fill_a), .full(full_a));

    param_shift_reg #(.WIDTH(8), .DEPTH(4), .RST_VAL(8'hA5)) u_dut_b (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .mode(mode), .sin(sin), .pin(pin),
        .q(q_b), .sout_r(sr_b), .sout_l(sl_b), .fill(fill_b), .full(full_b));

    param_shift_reg #(.WIDTH(8), .DEPTH(1), .RST_VAL(8'h00)) u_dut_c (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .mode(mode), .sin(sin), .pin(pin[7:0]),
        .q(q_c), .sout_r(sr_c), .sout_l(sl_c), .fill(fill_c), .full(full_c));

    // Reference model: per instance, an array of words indexed by stage number.
    int         m_depth [3] = '{4, 4, 1};
    logic [7:0] m_rstv  [3] = '{8'h00, 8'hA5, 8'h00};
    logic [7:0] m_w     [3][4];
    int         m_fill  [3];

    always @(posedge clk or posedge rst) begin : model
        logic [7:0] nw [4];
        int         nf;
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 4; i++) nw[i] = m_w[k][i];
            nf = m_fill[k];
            if (rst || clr) begin
                for (int i = 0; i < 4; i++) nw[i] = m_rstv[k];
                nf = 0;
            end else if (en) begin
                if (mode == 2'b01) begin
                    for (int i = 1; i < m_depth[k]; i++) nw[i] = m_w[k][i-1];
                    nw[0] = sin;
                    nf = (m_fill[k] + 1 > m_depth[k]) ? m_depth[k] : m_fill[k] + 1;
                end else if (mode == 2'b10) begin
                    for (int i = 0; i < m_depth[k] - 1; i++) nw[i] = m_w[k][i+1];
                    nw[m_depth[k]-1] = sin;
                    nf = (m_fill[k] + 1 > m_depth[k]) ? m_depth[k] : m_fill[k] + 1;
                end else if (mode == 2'b11) begin
                    for (int i = 0; i < m_depth[k]; i++) nw[i] = pin[8*i +: 8];
                    nf = m_depth[k];
                end
            end
            for (int i = 0; i < 4; i++) m_w[k][i] <= nw[i];
            m_fill[k] <= nf;
        end
    end

    function automatic logic [31:0] model_q(input int k);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < m_depth[k]; i++) r[8*i +: 8] = m_w[k][i];
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic cmp_inst(input int k, input logic [31:0] aq, input logic [7:0] asr,
                            input logic [7:0] asl, input int afill, input logic afull);
        int d;
        d = m_depth[k];
        chk($sformatf("q[%0d]", k), aq, model_q(k));
        chk($sformatf("sout_r[%0d]", k), {24'h0, asr}, {24'h0, m_w[k][d-1]});
        chk($sformatf("sout_l[%0d]", k), {24'h0, asl}, {24'h0, m_w[k][0]});
        chk($sformatf("fill[%0d]", k), afill, m_fill[k]);
        chk($sformatf("full[%0d]", k), {31'h0, afull}, {31'h0, m_fill[k] == d});
    endtask

    always @(negedge clk) begin
        if (cmp_on) begin
            cmp_inst(0, q_a, sr_a, sl_a, int'(fill_a), full_a);
            cmp_inst(1, q_b, sr_b, sl_b, int'(fill_b), full_b);
            cmp_inst(2, {24'h0, q_c}, sr_c, sl_c, int'(fill_c), full_c);
        end
    end

    task automatic step(input logic ien, input logic iclr, input logic [1:0] imode,
                        input logic [7:0] isin, input logic [31:0] ipin);
        @(negedge clk);
        #1;
        en = ien; clr = iclr; mode = imode; sin = isin; pin = ipin;
        @(posedge clk);
        #1;
    endtask

    logic [7:0] rs_sin [5]  = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    int         rs_fill [5] = '{1, 2, 3, 4, 4};

    initial begin
        rst = 1'b1; en = 1'b0; clr = 1'b0; mode = 2'b00; sin = '0; pin = '0;
        @(posedge clk);
        cmp_on = 1'b1;
        @(posedge clk);
        #1;
        chk("reset q_b", q_b, 32'hA5A5A5A5);
        @(negedge clk);
        #1 rst = 1'b0;

        // Right shift stream with fill saturating at 4
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 2'b01, rs_sin[i], 32'h0);
            chk($sformatf("rshift fill %0d", i), {29'h0, fill_a}, rs_fill[i]);
        end
        chk("rshift q", q_a, 32'h22334455);
        chk("rshift sout_r", {24'h0, sr_a}, 32'h22);
        chk("rshift full", {31'h0, full_a}, 32'h1);

        // Load then one left shift
        step(1'b1, 1'b0, 2'b11, 8'h00, 32'hAABBCCDD);
        step(1'b1, 1'b0, 2'b10, 8'hEE, 32'h0);
        chk("lshift q", q_a, 32'hEEAABBCC);
        chk("lshift sout_l", {24'h0, sl_a}, 32'hCC);
        chk("lshift fill", {29'h0, fill_a}, 32'd4);

        // Asynchronous reset mid-run
        step(1'b1, 1'b0, 2'b11, 8'h00, 32'hDEADBEEF);
        chk("preload q", q_a, 32'hDEADBEEF);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("async rst q", q_a, 32'h0);
        chk("async rst fill", {29'h0, fill_a}, 32'h0);
        chk("async rst full", {31'h0, full_a}, 32'h0);
        step(1'b1, 1'b0, 2'b01, 8'h77, 32'h0);
        step(1'b1, 1'b0, 2'b11, 8'h77, 32'hFFFFFFFF);
        chk("rst held q", q_a, 32'h0);
        @(negedge clk);
        #1 rst = 1'b0; en = 1'b0;

        // Enable low and hold mode freeze everything
        step(1'b1, 1'b0, 2'b11, 8'h00, 32'h01020304);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 2'b01, 8'hFF, 32'h0);
        chk("en0 q", q_a, 32'h01020304);
        chk("en0 fill", {29'h0, fill_a}, 32'd4);
        step(1'b1, 1'b0, 2'b00, 8'hFF, 32'hFFFFFFFF);
        chk("hold q", q_a, 32'h01020304);

        // Clear beats parallel load
        step(1'b1, 1'b1, 2'b11, 8'h00, 32'h12345678);
        chk("clr q", q_a, 32'h0);
        chk("clr fill", {29'h0, fill_a}, 32'h0);
        chk("clr q rstval", q_b, 32'hA5A5A5A5);
        step(1'b1, 1'b0, 2'b01, 8'h9A, 32'h0);
        step(1'b0, 1'b1, 2'b00, 8'h00, 32'h0);
        chk("clr en0 q", q_a, 32'h0);

        // Single-stage configuration
        step(1'b1, 1'b0, 2'b01, 8'h3C, 32'h0);
        chk("d1 right q", {24'h0, q_c}, 32'h3C);
        chk("d1 full", {31'h0, full_c}, 32'h1);
        step(1'b1, 1'b0, 2'b10, 8'hC3, 32'h0);
        chk("d1 left q", {24'h0, q_c}, 32'hC3);
        chk("d1 sout eq", {24'h0, sr_c}, {24'h0, sl_c});
        chk("d1 fill", {31'h0, fill_c}, 32'h1);

        // Mixed directions without turnaround
        step(1'b1, 1'b0, 2'b01, 8'h01, 32'h0);
        step(1'b1, 1'b0, 2'b10, 8'h02, 32'h0);
        step(1'b1, 1'b0, 2'b01, 8'h03, 32'h0);
        step(1'b1, 1'b0, 2'b11, 8'h00, 32'h5A6B7C8D);
        step(1'b1, 1'b0, 2'b10, 8'h04, 32'h0);
        step(1'b0, 1'b0, 2'b00, 8'h00, 32'h0);

        @(negedge clk);
        cmp_on = 1'b0;
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
